// File: rtl/mssb_echo_responder.sv
//==============================================================================
// Module      : mssb_echo_responder (with companion cmn_uart)
// Description : Far-end peer of the MSSB loopback tester. Bytes received on
//               MSSB_RX are buffered in a small FIFO and echoed back on
//               MSSB_TX in arrival order. OPB-readable counters let the link
//               be qualified from both boards.
// Ports       : OPB_CLK, OPB_RST (async, active-high), OPB_ADDR[31:0]
//               (only [3:0] decoded), OPB_DI[31:0], MSSB_ECHO_RE,
//               MSSB_ECHO_WE, OPB_DO[31:0] (registered read data),
//               MSSB_TX (UART out), MSSB_RX (UART in).
// Registers   : 0 CTRL {invert, clr, echo_en}; 1 STATUS {tx_busy, overflow,
//               fifo_level}; 2 RX_BYTES; 3 TX_BYTES; 4 DROP_BYTES.
// Config      : define MSSB_ECHO_INVERT_EN to make CTRL[2] a live invert bit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

// Minimal byte UART: 8N1, LSB first, stream handshakes on both directions.
module cmn_uart #(
  parameter int BAUD_RATE       = 921600,
  parameter int CLOCK_FREQUENCY = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_stream_in,
  input  logic       data_stream_in_stb,
  output logic       data_stream_in_ack,
  output logic [7:0] data_stream_out,
  output logic       data_stream_out_stb,
  input  logic       data_stream_out_ack,
  output logic       tx,
  input  logic       rx,
  input  logic       uart_active,
  output logic [7:0] debug,
  output logic       next_command_ready
);
  localparam logic [15:0] c_BIT_LAST  = 16'(CLOCK_FREQUENCY / BAUD_RATE - 1);
  localparam logic [15:0] c_HALF_LAST = 16'(CLOCK_FREQUENCY / BAUD_RATE / 2 - 1);

  logic        r_rx_s1, r_rx_s2, r_rx_busy;
  logic [15:0] r_rx_cnt;
  logic [3:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;

  logic        r_tx_busy;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;
  logic [9:0]  r_tx_frame;

  // Receiver: bit 0 is the start bit (re-checked at its centre to reject
  // glitches), bits 1..8 are data, bit 9 is the stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1             <= 1'b1;
      r_rx_s2             <= 1'b1;
      r_rx_busy           <= 1'b0;
      r_rx_cnt            <= '0;
      r_rx_bit            <= '0;
      r_rx_shift          <= '0;
      data_stream_out     <= '0;
      data_stream_out_stb <= 1'b0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      if (data_stream_out_ack) data_stream_out_stb <= 1'b0;
      if (!r_rx_busy) begin
        if (uart_active && !r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= c_HALF_LAST;
          r_rx_bit  <= 4'd0;
        end
      end else if (r_rx_cnt != 16'd0) begin
        r_rx_cnt <= r_rx_cnt - 16'd1;
      end else begin
        r_rx_cnt <= c_BIT_LAST;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s2) r_rx_busy <= 1'b0;
          else         r_rx_bit  <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_s2) begin
            data_stream_out     <= r_rx_shift;
            data_stream_out_stb <= 1'b1;
          end
        end else begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 4'd1;
        end
      end
    end
  end

  // Transmitter: the ack is a one-cycle pulse issued when a byte is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx                 <= 1'b1;
      data_stream_in_ack <= 1'b0;
      r_tx_busy          <= 1'b0;
      r_tx_cnt           <= '0;
      r_tx_bit           <= '0;
      r_tx_frame         <= '1;
    end else begin
      data_stream_in_ack <= 1'b0;
      if (!r_tx_busy) begin
        if (uart_active && data_stream_in_stb && !data_stream_in_ack) begin
          data_stream_in_ack <= 1'b1;
          r_tx_busy          <= 1'b1;
          r_tx_frame         <= {1'b1, data_stream_in, 1'b0};
          tx                 <= 1'b0;
          r_tx_cnt           <= c_BIT_LAST;
          r_tx_bit           <= 4'd0;
        end
      end else if (r_tx_cnt != 16'd0) begin
        r_tx_cnt <= r_tx_cnt - 16'd1;
      end else if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
        tx        <= 1'b1;
      end else begin
        r_tx_frame <= {1'b1, r_tx_frame[9:1]};
        tx         <= r_tx_frame[1];
        r_tx_bit   <= r_tx_bit + 4'd1;
        r_tx_cnt   <= c_BIT_LAST;
      end
    end
  end

  assign debug              = {6'd0, r_rx_busy, r_tx_busy};
  assign next_command_ready = ~r_tx_busy;
endmodule

module mssb_echo_responder #(
  parameter int BAUD_RATE       = 921600,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int FIFO_AW         = 4
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [31:0] OPB_ADDR,
  input  logic [31:0] OPB_DI,
  input  logic        MSSB_ECHO_RE,
  input  logic        MSSB_ECHO_WE,
  output logic [31:0] OPB_DO,
  output logic        MSSB_TX,
  input  logic        MSSB_RX
);
  localparam int          c_DEPTH   = 2 ** FIFO_AW;
  localparam logic [19:0] c_CNT_MAX = 20'hFFFFF;

  typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_STB = 1'b1} tx_state_t;

  tx_state_t          r_state, w_next_state;
  logic               r_echo_en, r_clr, r_overflow;
  logic               w_invert;
  logic [19:0]        r_rx_bytes, r_tx_bytes, r_drop_bytes;
  logic [7:0]         r_fifo_mem [c_DEPTH];
  logic [FIFO_AW:0]   r_wr_ptr, r_rd_ptr, w_fifo_level;
  logic               w_empty, w_full;
  logic               w_accept, w_push, w_pop, w_drop, w_ovf, w_tx_done, w_tx_busy;
  logic [7:0]         r_data_stream_in;
  logic               r_data_stream_in_stb, w_data_stream_in_ack;
  logic [7:0]         w_data_stream_out;
  logic               w_data_stream_out_stb, r_data_stream_out_ack;
  logic [31:0]        w_rd_data;
  logic [7:0]         w_unused_debug;
  logic               w_unused_ncr;
  logic               w_unused_opb;

  assign w_unused_opb = ^{OPB_ADDR[31:4], OPB_DI[31:2]};

  cmn_uart #(
    .BAUD_RATE       (BAUD_RATE),
    .CLOCK_FREQUENCY (CLOCK_FREQUENCY)
  ) u_uart (
    .clk                 (OPB_CLK),
    .rst                 (OPB_RST),
    .data_stream_in      (r_data_stream_in),
    .data_stream_in_stb  (r_data_stream_in_stb),
    .data_stream_in_ack  (w_data_stream_in_ack),
    .data_stream_out     (w_data_stream_out),
    .data_stream_out_stb (w_data_stream_out_stb),
    .data_stream_out_ack (r_data_stream_out_ack),
    .tx                  (MSSB_TX),
    .rx                  (MSSB_RX),
    .uart_active         (1'b1),
    .debug               (w_unused_debug),
    .next_command_ready  (w_unused_ncr)
  );

  function automatic logic [19:0] f_sat_inc(input logic [19:0] v);
    return (v == c_CNT_MAX) ? v : v + 20'd1;
  endfunction

  // FIFO status from FIFO_AW+1 bit wrapping pointers.
  assign w_fifo_level = r_wr_ptr - r_rd_ptr;
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                        (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

  // A byte arriving during a clr pulse is discarded without being counted.
  assign w_accept = w_data_stream_out_stb & r_data_stream_out_ack & ~r_clr;
  assign w_push   = w_accept & r_echo_en & ~w_full;
  assign w_drop   = w_accept & ~w_push;
  assign w_ovf    = w_accept & r_echo_en & w_full;
  assign w_tx_busy = (r_state != TX_IDLE);

`ifdef MSSB_ECHO_INVERT_EN
  logic r_invert;
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) r_invert <= 1'b0;
    else if (MSSB_ECHO_WE && OPB_ADDR[3:0] == 4'd0) r_invert <= OPB_DI[2];
  end
  assign w_invert = r_invert;
`else
  assign w_invert = 1'b0;
`endif

  // TX FSM: state register.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) r_state <= TX_IDLE;
    else         r_state <= w_next_state;
  end

  // TX FSM: next state; a pop is suppressed during clr since the FIFO is
  // being flushed in that same cycle.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_tx_done    = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (r_echo_en && !w_empty && !r_clr) begin
          w_next_state = TX_STB;
          w_pop        = 1'b1;
        end
      end
      TX_STB: begin
        if (w_data_stream_in_ack) begin
          w_next_state = TX_IDLE;
          w_tx_done    = 1'b1;
        end
      end
      default: w_next_state = TX_IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (w_push) r_fifo_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_data_stream_out;
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      r_echo_en             <= 1'b0;
      r_clr                 <= 1'b0;
      r_overflow            <= 1'b0;
      r_rx_bytes            <= '0;
      r_tx_bytes            <= '0;
      r_drop_bytes          <= '0;
      r_wr_ptr              <= '0;
      r_rd_ptr              <= '0;
      r_data_stream_in      <= '0;
      r_data_stream_in_stb  <= 1'b0;
      r_data_stream_out_ack <= 1'b0;
    end else begin
      r_clr <= 1'b0;
      if (MSSB_ECHO_WE && OPB_ADDR[3:0] == 4'd0) begin
        r_echo_en <= OPB_DI[0];
        r_clr     <= OPB_DI[1];
      end

      r_data_stream_out_ack <= w_data_stream_out_stb & ~r_data_stream_out_ack;

      if (w_pop) begin
        r_data_stream_in     <= w_invert ? ~r_fifo_mem[r_rd_ptr[FIFO_AW-1:0]]
                                         :  r_fifo_mem[r_rd_ptr[FIFO_AW-1:0]];
        r_data_stream_in_stb <= 1'b1;
      end else if (w_tx_done) begin
        r_data_stream_in_stb <= 1'b0;
      end

      if (r_clr) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_rx_bytes   <= '0;
        r_drop_bytes <= '0;
        r_overflow   <= 1'b0;
        // An in-flight byte finishing during clr lands in the fresh count.
        r_tx_bytes   <= w_tx_done ? 20'd1 : 20'd0;
      end else begin
        if (w_push)    r_wr_ptr     <= r_wr_ptr + 1'b1;
        if (w_pop)     r_rd_ptr     <= r_rd_ptr + 1'b1;
        if (w_accept)  r_rx_bytes   <= f_sat_inc(r_rx_bytes);
        if (w_drop)    r_drop_bytes <= f_sat_inc(r_drop_bytes);
        if (w_ovf)     r_overflow   <= 1'b1;
        if (w_tx_done) r_tx_bytes   <= f_sat_inc(r_tx_bytes);
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (OPB_ADDR[3:0])
      4'd0: begin
        w_rd_data[0] = r_echo_en;
        w_rd_data[2] = w_invert;
      end
      4'd1: begin
        w_rd_data[FIFO_AW:0] = w_fifo_level;
        w_rd_data[16]        = r_overflow;
        w_rd_data[17]        = w_tx_busy;
      end
      4'd2:    w_rd_data[19:0] = r_rx_bytes;
      4'd3:    w_rd_data[19:0] = r_tx_bytes;
      4'd4:    w_rd_data[19:0] = r_drop_bytes;
      default: w_rd_data = '0;
    endcase
  end

  // Read data is only non-zero in the cycle following a read strobe.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST)           OPB_DO <= '0;
    else if (MSSB_ECHO_RE) OPB_DO <= w_rd_data;
    else                   OPB_DO <= '0;
  end
endmodule

`default_nettype wire

// File: tb/tb_mssb_echo_responder.sv
//==============================================================================
// Module      : tb_mssb_echo_responder
// Description : Directed self-checking bench for mssb_echo_responder. The UART
//               runs at 10 clocks per bit so the full byte sweep stays short.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mssb_echo_responder;
  localparam int c_CPB = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] opb_addr, opb_di, opb_do;
  logic        echo_re, echo_we;
  logic        mssb_tx, mssb_rx;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  mon_b;
  logic [31:0] rd;

  always #5 clk = ~clk;

  mssb_echo_responder #(
    .BAUD_RATE       (10000000),
    .CLOCK_FREQUENCY (100000000),
    .FIFO_AW         (4)
  ) dut (
    .OPB_CLK      (clk),
    .OPB_RST      (rst),
    .OPB_ADDR     (opb_addr),
    .OPB_DI       (opb_di),
    .MSSB_ECHO_RE (echo_re),
    .MSSB_ECHO_WE (echo_we),
    .OPB_DO       (opb_do),
    .MSSB_TX      (mssb_tx),
    .MSSB_RX      (mssb_rx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic opb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    opb_addr = {28'd0, a};
    opb_di   = d;
    echo_we  = 1'b1;
    @(negedge clk);
    echo_we  = 1'b0;
  endtask

  task automatic opb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    opb_addr = {28'd0, a};
    echo_re  = 1'b1;
    @(negedge clk);
    echo_re  = 1'b0;
    d        = opb_do;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    opb_read(a, d);
    check(tag, d, exp);
  endtask

  // 8N1 frame followed by one extra idle bit time.
  task automatic send_byte(input logic [7:0] b);
    mssb_rx = 1'b0;
    repeat (c_CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      mssb_rx = b[k];
      repeat (c_CPB) @(negedge clk);
    end
    mssb_rx = 1'b1;
    repeat (2 * c_CPB) @(negedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 32'(rx_q.size()), 32'(n));
  endtask

  // Decodes frames seen on MSSB_TX into rx_q.
  initial begin
    forever begin
      @(negedge clk);
      if (mssb_tx === 1'b0) begin
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (c_CPB) @(negedge clk);
          mon_b[k] = mssb_tx;
        end
        repeat (c_CPB) @(negedge clk);
        rx_q.push_back(mon_b);
      end
    end
  end

  initial begin
    int          cyc;
    logic [7:0]  last;
    rst = 1'b1; opb_addr = '0; opb_di = '0; echo_re = 1'b0; echo_we = 1'b0; mssb_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_stb", 32'(dut.r_data_stream_in_stb), 32'd0);
    check("rst_tx_idle", 32'(mssb_tx), 32'd1);
    for (int a = 0; a < 5; a++) read_check("rst_reg", 4'(a), 32'd0);
    read_check("undecoded", 4'd9, 32'd0);
    @(negedge clk);
    check("do_idle", opb_do, 32'd0);

    // Echo sweep 0x00..0xFF
    opb_write(4'd0, 32'd1);
    read_check("ctrl_en", 4'd0, 32'd1);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    wait_bytes("sweep_count", 256, 3000);
    for (int i = 0; i < 256 && i < rx_q.size(); i++) check("sweep_byte", 32'(rx_q[i]), 32'(i));
    read_check("sweep_rx", 4'd2, 32'd256);
    read_check("sweep_tx", 4'd3, 32'd256);
    read_check("sweep_drop", 4'd4, 32'd0);
    read_check("sweep_status", 4'd1, 32'd0);

    // Overflow: a priming byte is parked in TX_STB, then 20 bytes fill the
    // 16-entry FIFO and the last 4 are dropped.
    opb_write(4'd0, 32'd3);
    force dut.w_data_stream_in_ack = 1'b0;
    send_byte(8'h11);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h20 + i));
    repeat (20) @(negedge clk);
    read_check("ovf_status", 4'd1, 32'h0003_0010);
    read_check("ovf_drop", 4'd4, 32'd4);
    read_check("ovf_rx", 4'd2, 32'd21);
    read_check("ovf_tx", 4'd3, 32'd0);
    rx_q.delete();
    release dut.w_data_stream_in_ack;
    repeat (3000) @(negedge clk);
    // Priming byte plus the 16 buffered bytes.
    read_check("drain_tx", 4'd3, 32'd17);
    read_check("drain_status", 4'd1, 32'h0001_0000);
    last = (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'h00;
    check("drain_last", 32'(last), 32'h2F);

    // echo_en = 0: everything dropped, no overflow
    opb_write(4'd0, 32'd2);
    read_check("off_ctrl", 4'd0, 32'd0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i));
    repeat (20) @(negedge clk);
    read_check("off_drop", 4'd4, 32'd5);
    read_check("off_rx", 4'd2, 32'd5);
    read_check("off_tx", 4'd3, 32'd0);
    read_check("off_status", 4'd1, 32'd0);
    opb_write(4'd0, 32'd3);
    read_check("clr_rx", 4'd2, 32'd0);
    read_check("clr_tx", 4'd3, 32'd0);
    read_check("clr_drop", 4'd4, 32'd0);
    read_check("clr_status", 4'd1, 32'd0);
    read_check("clr_ctrl", 4'd0, 32'd1);

    // Asynchronous reset while a byte sits in TX_STB
    force dut.w_data_stream_in_ack = 1'b0;
    send_byte(8'h3C);
    check("pre_rst_stb", 32'(dut.r_data_stream_in_stb), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_stb", 32'(dut.r_data_stream_in_stb), 32'd0);
    check("async_rx_cnt", 32'(dut.r_rx_bytes), 32'd0);
    check("async_level", 32'(dut.w_fifo_level), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    release dut.w_data_stream_in_ack;
    read_check("post_rst_ctrl", 4'd0, 32'd0);
    read_check("post_rst_rx", 4'd2, 32'd0);
    repeat (200) @(negedge clk);
    rx_q.delete();
    opb_write(4'd0, 32'd1);
    fork
      send_byte(8'h96);
      begin
        cyc = 0;
        while (!(dut.r_data_stream_out_ack && dut.w_data_stream_out_stb) && cyc < 400) begin
          @(negedge clk);
          cyc++;
        end
        check("accept_seen", 32'(cyc < 400), 32'd1);
        @(negedge clk);
        check("lat_a1_stb", 32'(dut.r_data_stream_in_stb), 32'd0);
        @(negedge clk);
        check("lat_a2_stb", 32'(dut.r_data_stream_in_stb), 32'd1);
        check("lat_a2_data", 32'(dut.r_data_stream_in), 32'h96);
      end
    join
    wait_bytes("post_rst_count", 1, 400);
    check("post_rst_echo", 32'((rx_q.size() > 0) ? rx_q[0] : 8'h00), 32'h96);
    read_check("post_rst_tx", 4'd3, 32'd1);

    // Invert option
    opb_write(4'd0, 32'd5);
    rx_q.delete();
`ifdef MSSB_ECHO_INVERT_EN
    read_check("inv_ctrl", 4'd0, 32'd5);
`else
    read_check("inv_ctrl", 4'd0, 32'd1);
`endif
    send_byte(8'hA5);
    wait_bytes("inv_count", 1, 400);
    last = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
`ifdef MSSB_ECHO_INVERT_EN
    check("inv_echo", 32'(last), 32'h5A);
`else
    check("inv_echo", 32'(last), 32'hA5);
`endif
    read_check("inv_rx", 4'd2, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
